// File: rtl/step_recorder.sv
// Records button-selected 2-bit values into a small RAM: one write per debounced
// rec press, with occupancy count, full and sticky overflow flags.
module step_recorder #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int ADDR_WIDTH      = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  rec_n,
    input  logic [1:0]            data_n,
    input  logic                  clr,
    output logic                  write,
    output logic [ADDR_WIDTH-1:0] WriteAddr,
    output logic [7:0]            WriteData,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  full,
    output logic                  overflow,
    output logic [1:0]            led
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam int CW    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0]       CNT_LAST   = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [ADDR_WIDTH:0] COUNT_FULL = (ADDR_WIDTH + 1)'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WRITE = 2'd1,
        S_HOLD  = 2'd2
    } state_t;

    // Bit 2 carries rec, bits 1:0 carry data, through synchronizer and debouncer.
    logic [2:0]            r_sync1;
    logic [2:0]            r_sync2;
    logic [2:0]            r_db;
    logic [CW-1:0]         r_db_cnt [3];
    logic                  r_rec_db_d;
    state_t                r_state;
    logic [ADDR_WIDTH-1:0] r_wptr;
    logic                  w_press;

    assign w_press = r_db[2] & ~r_rec_db_d;
    assign full    = (count == COUNT_FULL);

    // Two-flop synchronizer on the inverted (active-high) buttons.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1 <= 3'b000;
            r_sync2 <= 3'b000;
        end else begin
            r_sync1 <= ~{rec_n, data_n};
            r_sync2 <= r_sync1;
        end
    end

    // Per-input debouncer: level flips after DEBOUNCE_CYCLES consecutive differing samples.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_db <= 3'b000;
            for (int i = 0; i < 3; i++) begin
                r_db_cnt[i] <= {CW{1'b0}};
            end
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (r_sync2[i] == r_db[i]) begin
                    r_db_cnt[i] <= {CW{1'b0}};
                end else if (r_db_cnt[i] == CNT_LAST) begin
                    r_db[i]     <= r_sync2[i];
                    r_db_cnt[i] <= {CW{1'b0}};
                end else begin
                    r_db_cnt[i] <= r_db_cnt[i] + CW'(1);
                end
            end
        end
    end

    // Control FSM; a clr in the WRITE cycle drops the pending increment since the
    // recording is emptied on that same edge anyway.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_rec_db_d <= 1'b0;
            r_wptr     <= {ADDR_WIDTH{1'b0}};
            count      <= {(ADDR_WIDTH + 1){1'b0}};
            overflow   <= 1'b0;
            write      <= 1'b0;
            WriteAddr  <= {ADDR_WIDTH{1'b0}};
            WriteData  <= 8'h00;
            led        <= 2'b00;
        end else begin
            r_rec_db_d <= r_db[2];
            write      <= 1'b0;
            if (clr) begin
                r_wptr   <= {ADDR_WIDTH{1'b0}};
                count    <= {(ADDR_WIDTH + 1){1'b0}};
                overflow <= 1'b0;
                r_state  <= r_db[2] ? S_HOLD : S_IDLE;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (w_press && full) begin
                            overflow <= 1'b1;
                            r_state  <= S_HOLD;
                        end else if (w_press) begin
                            write     <= 1'b1;
                            WriteAddr <= r_wptr;
                            WriteData <= {6'b000000, r_db[1:0]};
                            led       <= r_db[1:0];
                            r_state   <= S_WRITE;
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end
                    S_WRITE: begin
                        r_wptr  <= r_wptr + ADDR_WIDTH'(1);
                        count   <= count + (ADDR_WIDTH + 1)'(1);
                        r_state <= S_HOLD;
                    end
                    S_HOLD: begin
                        r_state <= r_db[2] ? S_HOLD : S_IDLE;
                    end
                    default: begin
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_step_recorder.sv
// Directed scenarios plus random button activity, checked every cycle against a
// queue-based model of the recording.
module tb_step_recorder;

    localparam int DBC   = 4;
    localparam int AW    = 2;
    localparam int DEPTH = 4;

    logic          clk    = 1'b0;
    logic          reset  = 1'b1;
    logic          rec_n  = 1'b1;
    logic [1:0]    data_n = 2'b11;
    logic          clr    = 1'b0;
    logic          write;
    logic [AW-1:0] WriteAddr;
    logic [7:0]    WriteData;
    logic [AW:0]   count;
    logic          full;
    logic          overflow;
    logic [1:0]    led;

    step_recorder #(.DEBOUNCE_CYCLES(DBC), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .reset(reset), .rec_n(rec_n), .data_n(data_n), .clr(clr),
        .write(write), .WriteAddr(WriteAddr), .WriteData(WriteData),
        .count(count), .full(full), .overflow(overflow), .led(led)
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;
    int wcnt     = 0;
    int addr_q[$];
    int data_q[$];

    // Reference model: raw-input history, run lengths and the recorded values as a queue.
    bit [2:0] m_s1, m_s2, m_lvl;
    bit       m_recd;
    int       m_run[3];
    int       m_phase;   // 0 idle, 1 writing, 2 waiting for release
    int       m_rec[$];
    bit       m_write, m_ovf;
    int       m_addr, m_data, m_led;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_step();
        bit [2:0] samp;
        bit [2:0] lvl_old;
        bit       recd_old;
        int       ph_old;
        if (reset) begin
            m_s1 = 3'b000; m_s2 = 3'b000; m_lvl = 3'b000; m_recd = 1'b0;
            for (int i = 0; i < 3; i++) m_run[i] = 0;
            m_phase = 0; m_rec.delete();
            m_write = 1'b0; m_ovf = 1'b0; m_addr = 0; m_data = 0; m_led = 0;
        end else begin
            samp = m_s2; lvl_old = m_lvl; recd_old = m_recd; ph_old = m_phase;
            m_s2 = m_s1;
            m_s1 = ~{rec_n, data_n};
            for (int i = 0; i < 3; i++) begin
                if (samp[i] != m_lvl[i]) begin
                    m_run[i]++;
                    if (m_run[i] == DBC) begin
                        m_lvl[i] = samp[i];
                        m_run[i] = 0;
                    end
                end else begin
                    m_run[i] = 0;
                end
            end
            m_recd  = lvl_old[2];
            m_write = 1'b0;
            if (ph_old == 1) m_rec.push_back(m_led);
            if (clr) begin
                m_rec.delete();
                m_ovf   = 1'b0;
                m_phase = lvl_old[2] ? 2 : 0;
            end else if (ph_old == 1) begin
                m_phase = 2;
            end else if (ph_old == 0 && lvl_old[2] && !recd_old) begin
                if (m_rec.size() == DEPTH) begin
                    m_ovf   = 1'b1;
                    m_phase = 2;
                end else begin
                    m_write = 1'b1;
                    m_addr  = m_rec.size();
                    m_data  = int'(lvl_old[1:0]);
                    m_led   = int'(lvl_old[1:0]);
                    m_phase = 1;
                end
            end else if (ph_old == 2 && !lvl_old[2]) begin
                m_phase = 0;
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_step();
        #1;
        if (write === 1'b1) begin
            wcnt++;
            addr_q.push_back(int'(WriteAddr));
            data_q.push_back(int'(WriteData));
        end
        check("write", 32'(write), 32'(m_write));
        check("WriteAddr", 32'(WriteAddr), 32'(m_addr));
        check("WriteData", 32'(WriteData), 32'(m_data));
        check("count", 32'(count), 32'(m_rec.size()));
        check("full", 32'(full), 32'(m_rec.size() == DEPTH));
        check("overflow", 32'(overflow), 32'(m_ovf));
        check("led", 32'(led), 32'(m_led));
    endtask

    task automatic steps(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    task automatic press(input bit [1:0] d);
        data_n = ~d;
        steps(8);
        rec_n = 1'b0;
        steps(12);
        rec_n = 1'b1;
        steps(12);
    endtask

    task automatic do_clr();
        clr = 1'b1;
        step();
        clr = 1'b0;
        steps(2);
    endtask

    initial begin
        steps(3);
        check("rst_count", 32'(count), 32'd0);
        check("rst_write", 32'(write), 32'd0);
        check("rst_led", 32'(led), 32'd0);
        reset = 1'b0;
        steps(2);

        // One long press with data_n=01 -> single write of value 2 at address 0
        data_n = 2'b01;
        steps(8);
        wcnt = 0; addr_q.delete(); data_q.delete();
        rec_n = 1'b0;
        steps(20);
        rec_n = 1'b1;
        steps(10);
        check("long_press_writes", 32'(wcnt), 32'd1);
        check("long_press_addr", 32'(addr_q[0]), 32'd0);
        check("long_press_data", 32'(data_q[0]), 32'h02);
        check("long_press_led", 32'(led), 32'h2);
        check("long_press_count", 32'(count), 32'd1);

        // Short glitch is filtered out
        wcnt = 0;
        rec_n = 1'b0;
        steps(3);
        rec_n = 1'b1;
        steps(12);
        check("glitch_writes", 32'(wcnt), 32'd0);
        check("glitch_count", 32'(count), 32'd1);

        // Fill the recording, then one press too many
        do_clr();
        check("clr_count", 32'(count), 32'd0);
        wcnt = 0; addr_q.delete(); data_q.delete();
        press(2'd0); press(2'd1); press(2'd2); press(2'd3); press(2'd0);
        check("fill_writes", 32'(wcnt), 32'd4);
        for (int i = 0; i < 4; i++) begin
            check("fill_addr", 32'(addr_q[i]), 32'(i));
            check("fill_data", 32'(data_q[i]), 32'(i));
        end
        check("fill_full", 32'(full), 32'd1);
        check("fill_overflow", 32'(overflow), 32'd1);
        check("fill_count", 32'(count), 32'd4);

        // clr coincident with a press wins
        do_clr();
        press(2'd1); press(2'd2);
        check("pre_clr_count", 32'(count), 32'd2);
        wcnt = 0;
        rec_n = 1'b0;
        for (int k = 0; k < 20 && !m_lvl[2]; k++) step();
        clr = 1'b1;
        step();
        clr = 1'b0;
        steps(5);
        rec_n = 1'b1;
        steps(10);
        check("clr_press_writes", 32'(wcnt), 32'd0);
        check("clr_press_count", 32'(count), 32'd0);
        check("clr_press_ovf", 32'(overflow), 32'd0);
        addr_q.delete();
        press(2'd3);
        check("after_clr_addr", 32'(addr_q[0]), 32'd0);

        // Reset landing in the WRITE cycle, button still held afterwards
        data_n = 2'b10;
        steps(8);
        rec_n = 1'b0;
        for (int k = 0; k < 20 && !m_write; k++) step();
        reset = 1'b1;
        step();
        check("rst_in_write_write", 32'(write), 32'd0);
        check("rst_in_write_count", 32'(count), 32'd0);
        check("rst_in_write_addr", 32'(WriteAddr), 32'd0);
        check("rst_in_write_data", 32'(WriteData), 32'd0);
        check("rst_in_write_led", 32'(led), 32'd0);
        steps(2);
        reset = 1'b0;
        wcnt = 0;
        steps(15);
        check("held_after_rst_writes", 32'(wcnt), 32'd1);
        check("held_after_rst_count", 32'(count), 32'd1);
        rec_n = 1'b1;
        steps(12);

        // Bouncy press
        wcnt = 0;
        for (int k = 0; k < 10; k++) begin
            rec_n = ~rec_n;
            step();
        end
        rec_n = 1'b0;
        steps(20);
        rec_n = 1'b1;
        steps(12);
        check("bouncy_writes", 32'(wcnt), 32'd1);

        // Random button activity with occasional clr and reset
        for (int k = 0; k < 4000; k++) begin
            if ($urandom_range(0, 99) < 8) rec_n = ~rec_n;
            if ($urandom_range(0, 99) < 4) data_n[0] = ~data_n[0];
            if ($urandom_range(0, 99) < 4) data_n[1] = ~data_n[1];
            clr   = ($urandom_range(0, 99) < 2);
            reset = ($urandom_range(0, 399) == 0);
            step();
        end
        clr = 1'b0;
        reset = 1'b0;
        steps(4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
